// File: rtl/mem_lsu_ctrl_if.sv
// Bundle between the MEM-stage load/store controller and its environment: the core-side
// request/response handshake plus the data-RAM port. "slave" is the controller's view;
// "master" is the core + RAM side.
interface mem_lsu_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned AW = $clog2(DEPTH);

  // Core request
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;

  // Core response
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  // Data RAM port
  logic             mem_write_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_write_en, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_write_en, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// Load/store controller for the data port of a word-wide RAM with 1-cycle synchronous read.
// One request outstanding; handles byte/half lane selection, sign/zero extension on loads and
// read-modify-write for sub-word stores.
// Optional feature: define MEM_MISALIGN_TRAP_EN to answer misaligned half/word accesses with
// rsp_err and no RAM access; otherwise low address bits are masked to natural alignment.
module mem_lsu_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input logic          clock,
  input logic          reset,
  mem_lsu_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StMerge, StResp} state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic [1:0]    off_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic          accept;
  logic          trap;
  logic [1:0]    off;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   lane_mask;
  logic [31:0]   merged;

  // Bits above the word index only alias onto the same RAM word.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:AW+2];

  assign accept = bus.req_valid && (state_q == StIdle) && !reset;

  // Decode the byte offset of the request and whether it must trap.
  always_comb begin
    unique case (bus.req_size)
      2'b00:   off = bus.req_addr[1:0];
      2'b01:   off = {bus.req_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    trap = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
           (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Capture request fields on acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      we_q       <= bus.req_we;
      size_q     <= bus.req_size;
      unsigned_q <= bus.req_unsigned;
      off_q      <= off;
      addr_q     <= bus.req_addr[AW+1:2];
      wdata_q    <= bus.req_wdata;
      err_q      <= trap;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = trap ? StResp : StAccess;
      StAccess: state_d = (we_q && !size_q[1]) ? StMerge : StResp;
      StMerge:  state_d = StResp;
      StResp:   state_d = StIdle;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    if (size_q == 2'b00) begin
      load_val  = {{24{shifted[7] & ~unsigned_q}}, shifted[7:0]};
      lane_mask = 32'h0000_00ff << {off_q, 3'b000};
    end else if (size_q == 2'b01) begin
      load_val  = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
      lane_mask = 32'h0000_ffff << {off_q, 3'b000};
    end else begin
      load_val  = bus.mem_rdata;
      lane_mask = 32'hffff_ffff;
    end
    merged = (bus.mem_rdata & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  end

  // Outputs; everything is forced low while reset is asserted so an aborted MERGE never writes.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = '0;
    bus.rsp_err      = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (!reset) begin
      unique case (state_q)
        StIdle: bus.req_ready = 1'b1;
        StAccess: begin
          bus.mem_addr = addr_q;
          if (we_q && size_q[1]) begin
            bus.mem_write_en = 1'b1;
            bus.mem_wdata    = wdata_q;
          end
        end
        StMerge: begin
          bus.mem_addr     = addr_q;
          bus.mem_write_en = 1'b1;
          bus.mem_wdata    = merged;
        end
        StResp: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_err   = err_q;
          if (!we_q && !err_q) bus.rsp_rdata = load_val;
        end
      endcase
    end
  end
endmodule
